// File: rtl/predictor_update_arbiter.sv
// Two-port branch-resolution update merger feeding the predictor's single update port.
// Optional macro PRED_UPD_BYPASS_EN: an update arriving at an idle, empty queue skips the FIFO.
module predictor_update_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        upd_valid,
  output logic [1:0]        upd_ready,
  input  logic [2*XLEN-1:0] upd_pc,
  input  logic [1:0]        upd_taken,
  input  logic [1:0]        upd_local_taken,
  input  logic [1:0]        upd_global_taken,
  input  logic              hold,
  output logic              result_cond_branch,
  output logic [XLEN-1:0]   result_PC,
  output logic              result_taken,
  output logic              result_local_taken,
  output logic              result_global_taken,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = XLEN + 3;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr1;
  logic             rr;
  logic [CNT_W-1:0] free, n_wr;
  logic [1:0]       acc, wr_en;
  logic [ENT_W-1:0] ent0, ent1, byp_ent;
  logic             drain, byp;

  always_comb begin
    free = CNT_W'(DEPTH) - count;
    // Last free slot goes to the round-robin owner unless the other port is idle.
    upd_ready[0] = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && (!rr || !upd_valid[1]));
    upd_ready[1] = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && ( rr || !upd_valid[0]));
    acc   = upd_valid & upd_ready;
    ent0  = {upd_pc[XLEN-1:0], upd_taken[0], upd_local_taken[0], upd_global_taken[0]};
    ent1  = {upd_pc[2*XLEN-1:XLEN], upd_taken[1], upd_local_taken[1], upd_global_taken[1]};
    drain = !hold && (count != '0);
`ifdef PRED_UPD_BYPASS_EN
    byp     = !hold && (count == '0) && (|acc);
    byp_ent = acc[0] ? ent0 : ent1;
    // The older accepted update goes straight out; a younger port-1 update still queues.
    wr_en   = byp ? (acc[0] ? {acc[1], 1'b0} : 2'b00) : acc;
`else
    byp     = 1'b0;
    byp_ent = ent0;
    wr_en   = acc;
`endif
    wr_ptr1 = wr_ptr + PTR_W'(wr_en[0]);
    n_wr    = CNT_W'(wr_en[0]) + CNT_W'(wr_en[1]);
  end

  // Queue storage: port 0 lands at the tail, port 1 right behind it.
  always_ff @(posedge clock) begin
    if (wr_en[0]) mem[wr_ptr]  <= ent0;
    if (wr_en[1]) mem[wr_ptr1] <= ent1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      rr                  <= 1'b0;
      result_cond_branch  <= 1'b0;
      result_PC           <= '0;
      result_taken        <= 1'b0;
      result_local_taken  <= 1'b0;
      result_global_taken <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr1 + PTR_W'(wr_en[1]);
      if (drain) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + n_wr - CNT_W'(drain);
      if ((&upd_valid) && (free == CNT_W'(1))) rr <= ~rr;
      result_cond_branch <= drain | byp;
      if (drain)
        {result_PC, result_taken, result_local_taken, result_global_taken} <= mem[rd_ptr];
      else if (byp)
        {result_PC, result_taken, result_local_taken, result_global_taken} <= byp_ent;
    end
  end

endmodule

// File: tb/tb_predictor_update_arbiter.sv
// Bench for predictor_update_arbiter: reference model + payload scoreboard, table and sequences.
module tb_predictor_update_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef PRED_UPD_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        upd_valid = '0;
  logic [1:0]        upd_ready;
  logic [2*XLEN-1:0] upd_pc = '0;
  logic [1:0]        upd_taken = '0, upd_local_taken = '0, upd_global_taken = '0;
  logic              hold = 1'b0;
  logic              result_cond_branch;
  logic [XLEN-1:0]   result_PC;
  logic              result_taken, result_local_taken, result_global_taken;
  logic [CNT_W-1:0]  count;

  predictor_update_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_local_taken(upd_local_taken),
    .upd_global_taken(upd_global_taken), .hold(hold),
    .result_cond_branch(result_cond_branch), .result_PC(result_PC),
    .result_taken(result_taken), .result_local_taken(result_local_taken),
    .result_global_taken(result_global_taken), .count(count)
  );

  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [34:0] sb[$];
  logic [34:0] last = '0;
  int          m_count = 0;
  bit          m_rr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, check ready against the model, advance, check outputs.
  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] t, input logic [1:0] l, input logic [1:0] g,
                      input logic h, output logic [1:0] rdy_s, output logic strb);
    int free;
    logic [1:0] er, acc;
    bit drn, byp, exp_strobe;
    upd_valid = v; upd_pc = {p1, p0}; upd_taken = t; upd_local_taken = l;
    upd_global_taken = g; hold = h;
    #1;
    free  = DEPTH - m_count;
    er[0] = (free >= 2) || (free == 1 && (!m_rr || !v[1]));
    er[1] = (free >= 2) || (free == 1 && ( m_rr || !v[0]));
    rdy_s = upd_ready;
    chk("upd_ready", upd_ready, er);
    acc = v & er;
    if (acc[0]) sb.push_back({p0, t[0], l[0], g[0]});
    if (acc[1]) sb.push_back({p1, t[1], l[1], g[1]});
    drn = !h && m_count > 0;
    byp = BYP && !h && m_count == 0 && (acc != 2'b00);
    exp_strobe = drn || byp;
    if (v == 2'b11 && free == 1) m_rr = ~m_rr;
    m_count = m_count + int'(acc[0]) + int'(acc[1]) - int'(exp_strobe);
    @(posedge clock);
    #1;
    strb = result_cond_branch;
    chk("strobe", result_cond_branch, exp_strobe);
    if (exp_strobe) begin
      if (sb.size() == 0) chk("scoreboard_underflow", 1, 0);
      else last = sb.pop_front();
    end
    chk("payload", {result_PC, result_taken, result_local_taken, result_global_taken}, last);
    chk("count", count, m_count);
  endtask

  task automatic idle(input logic h, output logic strb);
    logic [1:0] r;
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, h, r, strb);
  endtask

  task automatic do_reset();
    upd_valid = 2'b00; hold = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_strobe", result_cond_branch, 0);
    chk("rst_payload", {result_PC, result_taken, result_local_taken, result_global_taken}, 0);
    chk("rst_ready", upd_ready, 2'b11);
    sb.delete(); m_count = 0; m_rr = 1'b0; last = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] valid;
    logic       hold;
    logic [1:0] exp_ready;
    int         exp_count;
  } vec_t;
  vec_t tab[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r;
    logic s;
    int first, nst, prev;
    bit consec;

    tab[0]  = '{2'b11, 1'b1, 2'b11, 2};
    tab[1]  = '{2'b01, 1'b1, 2'b11, 3};
    tab[2]  = '{2'b11, 1'b1, 2'b01, 4};
    tab[3]  = '{2'b11, 1'b1, 2'b00, 4};
    tab[4]  = '{2'b00, 1'b0, 2'b00, 3};
    tab[5]  = '{2'b11, 1'b1, 2'b10, 4};
    tab[6]  = '{2'b00, 1'b0, 2'b00, 3};
    tab[7]  = '{2'b11, 1'b1, 2'b01, 4};
    tab[8]  = '{2'b10, 1'b0, 2'b00, 3};
    tab[9]  = '{2'b10, 1'b1, 2'b10, 4};
    tab[10] = '{2'b01, 1'b0, 2'b00, 3};
    tab[11] = '{2'b11, 1'b1, 2'b10, 4};
    tab[12] = '{2'b00, 1'b0, 2'b00, 3};
    tab[13] = '{2'b00, 1'b0, 2'b11, 2};
    tab[14] = '{2'b00, 1'b0, 2'b11, 1};
    tab[15] = '{2'b00, 1'b0, 2'b11, 0};
    tab[16] = '{2'b00, 1'b0, 2'b11, 0};

    #2;
    do_reset();

    // Single update, latency and payload
    first = -1;
    step(2'b01, 32'h0000_1040, 32'h0, 2'b01, 2'b01, 2'b00, 1'b0, r, s);
    if (s && first < 0) first = 1;
    for (int i = 2; i <= 4; i++) begin
      idle(1'b0, s);
      if (s && first < 0) first = i;
    end
    chk("single_latency", first, LAT);
    chk("single_count", count, 0);

    // Dual accept: two strobes on consecutive cycles
    nst = 0; prev = -10; consec = 1'b1;
    step(2'b11, 32'h100, 32'h200, 2'b10, 2'b01, 2'b11, 1'b0, r, s);
    if (s) begin nst++; prev = 0; end
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0, s);
      if (s) begin
        if (nst > 0 && prev != i - 1) consec = 1'b0;
        nst++; prev = i;
      end
    end
    chk("dual_strobes", nst, 2);
    chk("dual_consecutive", consec, 1);

    // Contention table under hold
    for (int i = 0; i < 17; i++) begin
      step(tab[i].valid, 32'h1000 + i * 16, 32'h2000 + i * 16, i[1:0], i[2:1], i[3:2],
           tab[i].hold, r, s);
      chk($sformatf("tab%0d_ready", i), r, tab[i].exp_ready);
      chk($sformatf("tab%0d_count", i), count, tab[i].exp_count);
    end

    // Hold: 3 queued, 5 held cycles, then 3 back-to-back strobes
    for (int i = 0; i < 3; i++)
      step(2'b01, 32'h5000 + i * 4, 32'h0, 2'b01, 2'b00, 2'b01, 1'b1, r, s);
    nst = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, s);
      if (s) nst++;
    end
    chk("hold_no_strobe", nst, 0);
    chk("hold_count", count, 3);
    nst = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, s);
      if (s) nst++;
    end
    chk("hold_release_strobes", nst, 3);
    chk("hold_release_count", count, 0);

    // Wrap: 10 updates on port 1 with continuous drain
    nst = 0;
    for (int i = 0; i < 10; i++) begin
      step(2'b10, 32'h0, 32'h3000 + i * 4, 2'b10, {i[0], 1'b0}, {i[1], 1'b0}, 1'b0, r, s);
      if (s) nst++;
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, s);
      if (s) nst++;
    end
    chk("wrap_strobes", nst, 10);
    chk("wrap_empty", count, 0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++)
      step(2'b01, 32'h7000 + i * 4, 32'h0, 2'b01, 2'b01, 2'b01, 1'b1, r, s);
    chk("pre_reset_count", count, 3);
    do_reset();
    idle(1'b0, s);
    chk("post_reset_no_strobe", s, 0);
    idle(1'b0, s);
    chk("post_reset_ready", upd_ready, 2'b11);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
